ddr2_v11_0_if_csr_m0_p2b_converter: RTL and testbench
=====================================================

DDR2_V11_0_IF_CSR_M0_P2B_CONVERTER -- requirements
Module: ddr2_v11_0_if_csr_m0_p2b_converter

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 8, meaning the width of in_channel (1..8).
REQ-002 SHALL have parameter CHANNEL_EVERY_SOP, default 0, meaning a value of 1 emits the channel header on every SOP beat even when the channel is unchanged.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_ready  output  1  upstream may transfer a beat this cycle.
REQ-006 SHALL have port in_valid  input  1  in_data/in_channel/in_startofpacket/in_endofpacket are valid.
REQ-007 SHALL have port in_data  input  8  packet payload byte.
REQ-008 SHALL have port in_channel  input  CHANNEL_WIDTH  channel of the beat.
REQ-009 SHALL have ports in_startofpacket and in_endofpacket  input  1 each  packet delimiters.
REQ-010 SHALL have port out_ready  input  1  downstream accepts a byte.
REQ-011 SHALL have port out_valid  output  1  out_data holds an encoded byte.
REQ-012 SHALL have port out_data  output  8  encoded byte stream with no sideband.

Function
REQ-013 SHALL encode each input beat as this byte sequence, in order: [0x7C, ch] if a channel header is required; [0x7A] if SOP; [0x7B] if EOP; then the data byte.
REQ-014 SHALL emit any ch or data byte in 0x7A..0x7D as the pair 0x7D, (byte XOR 0x20); all other bytes pass unchanged.
REQ-015 SHALL zero-extend ch to 8 bits.
REQ-016 SHALL require a channel header on the first beat after reset, on any beat whose in_channel differs from last_channel, and on every SOP beat when CHANNEL_EVERY_SOP=1.
REQ-017 SHALL update last_channel only when the beat is consumed.
REQ-018 SHALL step an FSM through states IDLE, CHAN_CHAR, CHAN_ESC, CHAN_VAL, SOP_CHAR, EOP_CHAR, DATA_ESC, DATA, skipping inapplicable states.
REQ-019 SHALL make the FSM decide from IDLE combinationally, so a beat with no markers and no escaping produces its data byte in the same load cycle.
REQ-020 SHALL register out_valid/out_data; the output register loads when !out_valid || out_ready, and otherwise holds its value stable.
REQ-021 SHALL assert in_ready only in the cycle the final data byte of the current beat loads into the output register; a beat transfers when in_valid && in_ready.
REQ-022 SHALL NOT consume input, and the FSM SHALL NOT advance, while the output register is full and out_ready=0.
REQ-023 SHALL sustain throughput of one output byte per cycle with out_ready held high; latency is in_valid to first out_valid = 1 cycle.
REQ-024 SHALL leave the FSM in IDLE with out_valid deasserted after out_ready if in_valid drops between beats.
REQ-025 SHALL perform no packet-integrity checks: a beat with both SOP and EOP is legal, and EOP without a preceding SOP is encoded as given.

Reset
REQ-026 SHALL, while reset=1, synchronously force out_valid=0, out_data=0x00, FSM=IDLE, last_channel=0, chan_sent=0 (so the first beat carries a header), and in_ready=0.
REQ-027 SHALL, on reset mid-sequence, discard the partially emitted beat (no completion); the upstream beat remains unconsumed.

Structure
REQ-028 SHALL define the constants SOP_CHAR=0x7A, EOP_CHAR=0x7B, CHAN_CHAR=0x7C, ESC_CHAR=0x7D and ESC_XOR=0x20, together with the FSM state encoding, in shared package ddr2_v11_0_p2b_pkg, reused by the byte-to-packet decoder.
REQ-029 SHALL place the escape detection/transform (needs_esc, escaped byte) in sub-module ddr2_v11_0_if_csr_m0_p2b_escape, instantiated for both ch and data.

Verification
REQ-030 SHALL verify that after reset, with out_ready=1, beats ch0 {0x11 SOP, 0x22 EOP} produce 7C 00 7A 11 7B 22.
REQ-031 SHALL verify that a mid-packet data byte 0x7B on the same channel produces 7D 5B, with in_ready high only on the 5B load.
REQ-032 SHALL verify that a channel change to 0x7D produces 7C 7D 5D before the data, and that the following beat on 0x7D has no header.
REQ-033 SHALL verify that a single-beat packet (SOP+EOP, data 0x7A, same channel) produces 7A 7B 7D 5A.
REQ-034 SHALL verify that with out_ready toggled randomly, out_data is held stable while out_valid && !out_ready, and no bytes are lost or duplicated against the reference encoding.
REQ-035 SHALL verify that reset asserted after 7C is emitted yields out_valid=0 the next cycle, and that the next beat begins again with a 7C header.

Source files
------------

// File: rtl/ddr2_v11_0_p2b_pkg.sv
// Shared framing constants and FSM encoding for the packet-to-byte encoder and
// the matching byte-to-packet decoder.
package ddr2_v11_0_p2b_pkg;

   localparam logic [7:0] SOP_CHAR  = 8'h7A;
   localparam logic [7:0] EOP_CHAR  = 8'h7B;
   localparam logic [7:0] CHAN_CHAR = 8'h7C;
   localparam logic [7:0] ESC_CHAR  = 8'h7D;
   localparam logic [7:0] ESC_XOR   = 8'h20;

   typedef enum logic [2:0] {
      StIdle,
      StChanChar,
      StChanEsc,
      StChanVal,
      StSopChar,
      StEopChar,
      StDataEsc,
      StData
   } p2b_state_e;

   // Step that follows cur for a beat with the given needs; from StIdle this is
   // the first byte of the beat. Inapplicable steps are skipped.
   function automatic p2b_state_e p2b_next_step(input p2b_state_e cur,
                                                input logic hdr,
                                                input logic ch_esc,
                                                input logic sop,
                                                input logic eop,
                                                input logic data_esc);
      p2b_state_e to_data;
      p2b_state_e to_eop;
      p2b_state_e to_sop;
      p2b_state_e nxt;
      to_data = data_esc ? StDataEsc : StData;
      to_eop  = eop ? StEopChar : to_data;
      to_sop  = sop ? StSopChar : to_eop;
      unique case (cur)
         StIdle:     nxt = hdr ? StChanChar : to_sop;
         StChanChar: nxt = ch_esc ? StChanEsc : StChanVal;
         StChanEsc:  nxt = StChanVal;
         StChanVal:  nxt = to_sop;
         StSopChar:  nxt = to_eop;
         StEopChar:  nxt = to_data;
         StDataEsc:  nxt = StData;
         StData:     nxt = StIdle;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/ddr2_v11_0_if_csr_m0_p2b_escape.sv
// Detects bytes that collide with framing characters and produces their
// escaped form (the byte following ESC_CHAR).
module ddr2_v11_0_if_csr_m0_p2b_escape
   import ddr2_v11_0_p2b_pkg::*;
(
   input  logic [7:0] data_i,
   output logic       needs_esc_o,
   output logic [7:0] escaped_o
);

   assign needs_esc_o = (data_i >= SOP_CHAR) && (data_i <= ESC_CHAR);
   assign escaped_o   = data_i ^ ESC_XOR;

endmodule

// File: rtl/ddr2_v11_0_if_csr_m0_p2b_converter.sv
// Packet-to-byte encoder: serialises channel/SOP/EOP/data beats into a single
// escaped byte stream behind a registered output stage.
module ddr2_v11_0_if_csr_m0_p2b_converter
   import ddr2_v11_0_p2b_pkg::*;
#(
   parameter int unsigned CHANNEL_WIDTH     = 8,
   parameter int unsigned CHANNEL_EVERY_SOP = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic [CHANNEL_WIDTH-1:0] in_channel,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data
);

   logic [7:0]               ch8, ch_escaped, data_escaped, emit_byte;
   logic                     ch_needs_esc, data_needs_esc;
   logic                     need_hdr, load, go, beat_done;
   logic [CHANNEL_WIDTH-1:0] last_channel_q, last_channel_d;
   logic                     chan_sent_q, chan_sent_d;
   logic                     out_valid_q, out_valid_d;
   logic [7:0]               out_data_q, out_data_d;
   p2b_state_e               state_q, state_d, emit_st;

   assign ch8 = 8'(in_channel);

   ddr2_v11_0_if_csr_m0_p2b_escape u_ch_esc (
      .data_i      (ch8),
      .needs_esc_o (ch_needs_esc),
      .escaped_o   (ch_escaped)
   );

   ddr2_v11_0_if_csr_m0_p2b_escape u_data_esc (
      .data_i      (in_data),
      .needs_esc_o (data_needs_esc),
      .escaped_o   (data_escaped)
   );

   assign need_hdr = !chan_sent_q || (in_channel != last_channel_q) ||
                     ((CHANNEL_EVERY_SOP != 0) && in_startofpacket);
   assign load     = !out_valid_q || out_ready;
   assign go       = load && in_valid;

   // From idle the first step is resolved combinationally so a plain beat
   // emits its data byte in the same load cycle.
   assign emit_st   = (state_q == StIdle) ?
                      p2b_next_step(StIdle, need_hdr, ch_needs_esc, in_startofpacket,
                                    in_endofpacket, data_needs_esc) : state_q;
   assign beat_done = go && (emit_st == StData);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (go) begin
         state_d = p2b_next_step(emit_st, need_hdr, ch_needs_esc, in_startofpacket,
                                 in_endofpacket, data_needs_esc);
      end
   end

   always_comb begin
      emit_byte = 8'h00;
      unique case (emit_st)
         StIdle:     emit_byte = 8'h00;
         StChanChar: emit_byte = CHAN_CHAR;
         StChanEsc:  emit_byte = ESC_CHAR;
         StChanVal:  emit_byte = ch_needs_esc ? ch_escaped : ch8;
         StSopChar:  emit_byte = SOP_CHAR;
         StEopChar:  emit_byte = EOP_CHAR;
         StDataEsc:  emit_byte = ESC_CHAR;
         StData:     emit_byte = data_needs_esc ? data_escaped : in_data;
      endcase
      in_ready = beat_done && !reset;
   end

   always_comb begin
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      last_channel_d = last_channel_q;
      chan_sent_d    = chan_sent_q;
      if (load) begin
         out_valid_d = in_valid;
         if (in_valid) begin
            out_data_d = emit_byte;
         end
      end
      if (in_ready) begin
         last_channel_d = in_channel;
         chan_sent_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q    <= 1'b0;
         out_data_q     <= 8'h00;
         last_channel_q <= '0;
         chan_sent_q    <= 1'b0;
      end else begin
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         last_channel_q <= last_channel_d;
         chan_sent_q    <= chan_sent_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_ddr2_v11_0_if_csr_m0_p2b_converter.sv
// Directed bench for the packet-to-byte encoder with hand-encoded byte streams.
module tb_ddr2_v11_0_if_csr_m0_p2b_converter;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_ready;
   logic       in_valid;
   logic [7:0] in_data;
   logic [7:0] in_channel;
   logic       in_startofpacket;
   logic       in_endofpacket;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   logic       held_v = 1'b0;
   logic [7:0] held_d = 8'h00;
   logic       rand_done;

   ddr2_v11_0_if_csr_m0_p2b_converter #(
      .CHANNEL_WIDTH     (8),
      .CHANNEL_EVERY_SOP (0)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .in_ready         (in_ready),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_channel       (in_channel),
      .in_startofpacket (in_startofpacket),
      .in_endofpacket   (in_endofpacket),
      .out_ready        (out_ready),
      .out_valid        (out_valid),
      .out_data         (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Collects accepted bytes and checks the output holds while stalled.
   always @(negedge clk) begin
      if (reset) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(held_d));
         end
         held_v = out_valid && !out_ready;
         held_d = out_data;
         if (out_valid && out_ready) got_q.push_back(out_data);
      end
   end

   // Presents one beat until consumed; exp holds the n encoded bytes, first byte
   // in the most significant used position.
   task automatic send_beat(input logic [7:0] ch, input logic [7:0] data, input logic sop,
                            input logic eop, input logic [47:0] exp, input int n,
                            input bit chk_timing);
      int  cycles;
      bit  done;
      cycles           = 0;
      done             = 1'b0;
      in_channel       = ch;
      in_data          = data;
      in_startofpacket = sop;
      in_endofpacket   = eop;
      in_valid         = 1'b1;
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(exp[8*i +: 8]);
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         cycles++;
         if (in_ready) done = 1'b1;
      end
      if (!done) begin
         check("beat_timeout", 32'd0, 32'd1);
      end else begin
         if (chk_timing) check("ready_cycle", 32'(cycles), 32'(n));
         @(posedge clk);
         #1;
         check("final_byte", 32'(out_data), 32'(exp[7:0]));
      end
      in_valid = 1'b0;
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset            = 1'b1;
      in_valid         = 1'b0;
      in_data          = 8'h00;
      in_channel       = 8'h00;
      in_startofpacket = 1'b0;
      in_endofpacket   = 1'b0;
      out_ready        = 1'b1;
      rand_done        = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'h00);
      check("rst_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // First beats after reset carry a header; same channel afterwards does not.
      send_beat(8'h00, 8'h11, 1'b1, 1'b0, 48'h7C007A11, 4, 1'b1);
      send_beat(8'h00, 8'h22, 1'b0, 1'b1, 48'h7B22, 2, 1'b1);
      send_beat(8'h00, 8'h7B, 1'b0, 1'b0, 48'h7D5B, 2, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_ready", 32'(in_ready), 32'd0);
      send_beat(8'h7D, 8'h33, 1'b0, 1'b0, 48'h7C7D5D33, 4, 1'b1);
      send_beat(8'h7D, 8'h44, 1'b0, 1'b0, 48'h44, 1, 1'b1);
      send_beat(8'h7D, 8'h7A, 1'b1, 1'b1, 48'h7A7B7D5A, 4, 1'b1);
      send_beat(8'h7D, 8'h7C, 1'b0, 1'b0, 48'h7D5C, 2, 1'b1);
      send_beat(8'h7D, 8'h7E, 1'b0, 1'b0, 48'h7E, 1, 1'b1);
      send_beat(8'h7D, 8'h79, 1'b0, 1'b1, 48'h7B79, 2, 1'b1);
      repeat (3) @(posedge clk);
      compare_stream("directed");

      // Random backpressure.
      fork
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      send_beat(8'h03, 8'h7D, 1'b1, 1'b0, 48'h7C037A7D5D, 5, 1'b0);
      send_beat(8'h03, 8'h55, 1'b0, 1'b0, 48'h55, 1, 1'b0);
      send_beat(8'h03, 8'h7B, 1'b0, 1'b1, 48'h7B7D5B, 3, 1'b0);
      send_beat(8'h7A, 8'h00, 1'b1, 1'b1, 48'h7C7D5A7A7B00, 6, 1'b0);
      send_beat(8'h7A, 8'h7E, 1'b0, 1'b0, 48'h7E, 1, 1'b0);
      rand_done = 1'b1;
      repeat (3) @(posedge clk);
      #2 out_ready = 1'b1;
      repeat (5) @(posedge clk);
      compare_stream("backpressure");

      // Reset after the header character discards the beat.
      @(posedge clk);
      #1;
      in_channel       = 8'h05;
      in_data          = 8'h10;
      in_startofpacket = 1'b0;
      in_endofpacket   = 1'b0;
      in_valid         = 1'b1;
      @(posedge clk);
      #1;
      check("pre_rst_data", 32'(out_data), 32'h7C);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'h00);
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      got_q.delete();
      reset = 1'b0;
      send_beat(8'h05, 8'h10, 1'b0, 1'b0, 48'h7C0510, 3, 1'b1);
      repeat (3) @(posedge clk);
      compare_stream("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
